button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 67 ++++++
 tb/tb_button_debouncer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Multi-channel pushbutton debouncer: two-flop synchronizer, per-channel
// stability counter, debounced level plus one-cycle press/release pulses.
module button_debouncer #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [NUM_BTN-1:0] o_btn_stable,
  output logic [NUM_BTN-1:0] o_btn_press,
  output logic [NUM_BTN-1:0] o_btn_release,
  output logic [31:0]        o_btn_word
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] rel;
  logic [CW-1:0]      count [NUM_BTN];

  // Normalise polarity so a pressed button is always 1 internally.
  assign btn_in = ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      rel    <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        count[i] <= '0;
      end
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == stable[i]) begin
          count[i] <= '0;
        end else if (count[i] == CNT_MAX) begin
          // Level held long enough: commit it and pulse in the same edge.
          stable[i] <= sync2[i];
          count[i]  <= '0;
          press[i]  <= sync2[i];
          rel[i]    <= ~sync2[i];
        end else begin
          count[i] <= count[i] + CW'(1);
        end
      end
    end
  end

  assign o_btn_stable  = stable;
  assign o_btn_press   = press;
  assign o_btn_release = rel;
  assign o_btn_word    = 32'(stable);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4: an active-low
// instance for the main scenarios and an active-high instance for polarity.
module tb_button_debouncer;

  logic        clk;
  logic        rst;
  logic [3:0]  raw_a;
  logic [3:0]  stable_a, press_a, release_a;
  logic [31:0] word_a;
  logic [3:0]  raw_b;
  logic [3:0]  stable_b, press_b, release_b;
  logic [31:0] word_b;

  int compared   = 0;
  int mismatched = 0;

  button_debouncer #(.NUM_BTN(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut_a (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_btn_raw     (raw_a),
    .o_btn_stable  (stable_a),
    .o_btn_press   (press_a),
    .o_btn_release (release_a),
    .o_btn_word    (word_a)
  );

  button_debouncer #(.NUM_BTN(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)) dut_b (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_btn_raw     (raw_b),
    .o_btn_stable  (stable_b),
    .o_btn_press   (press_b),
    .o_btn_release (release_b),
    .o_btn_word    (word_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    raw_a = 4'hF;
    raw_b = 4'h0;
    tick(3);
    compared++;
    if (stable_a !== 4'h0 || press_a !== 4'h0 || release_a !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_a: stable=%h press=%h release=%h, required all 0", stable_a, press_a, release_a);
    end
    compared++;
    if (word_a !== 32'h0 || word_b !== 32'h0 || stable_b !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_word: word_a=%h word_b=%h stable_b=%h, required 0", word_a, word_b, stable_b);
    end
    rst = 1'b0;
    tick(8);
    compared++;
    if (stable_a !== 4'h0 || press_a !== 4'h0) begin
      mismatched++;
      $display("FAIL idle_after_reset: stable=%h press=%h, required 0", stable_a, press_a);
    end
  endtask

  task automatic test_single_press;
    raw_a = 4'hE;
    tick(5);
    compared++;
    if (stable_a !== 4'h0 || press_a !== 4'h0) begin
      mismatched++;
      $display("FAIL press_early k+4: stable=%h press=%h, required 0/0", stable_a, press_a);
    end
    tick(1);
    compared++;
    if (stable_a !== 4'h1 || press_a !== 4'h1 || release_a !== 4'h0 || word_a !== 32'h1) begin
      mismatched++;
      $display("FAIL press_k+5: stable=%h press=%h release=%h word=%h, required 1/1/0/00000001",
               stable_a, press_a, release_a, word_a);
    end
    tick(1);
    compared++;
    if (stable_a !== 4'h1 || press_a !== 4'h0) begin
      mismatched++;
      $display("FAIL press_k+6: stable=%h press=%h, required 1/0", stable_a, press_a);
    end
    raw_a = 4'hF;
    tick(5);
    compared++;
    if (stable_a !== 4'h1 || release_a !== 4'h0) begin
      mismatched++;
      $display("FAIL release_early: stable=%h release=%h, required 1/0", stable_a, release_a);
    end
    tick(1);
    compared++;
    if (stable_a !== 4'h0 || release_a !== 4'h1 || press_a !== 4'h0) begin
      mismatched++;
      $display("FAIL release_k+5: stable=%h release=%h press=%h, required 0/1/0", stable_a, release_a, press_a);
    end
    tick(1);
    compared++;
    if (release_a !== 4'h0) begin
      mismatched++;
      $display("FAIL release_k+6: release=%h, required 0", release_a);
    end
  endtask

  task automatic test_glitch;
    for (int rep = 0; rep < 5; rep++) begin
      for (int c = 0; c < 4; c++) begin
        raw_a = (c < 3) ? 4'hE : 4'hF;
        tick(1);
        compared++;
        if (stable_a !== 4'h0 || press_a !== 4'h0 || release_a !== 4'h0) begin
          mismatched++;
          $display("FAIL glitch rep%0d c%0d: stable=%h press=%h release=%h, required 0",
                   rep, c, stable_a, press_a, release_a);
        end
      end
    end
    tick(6);
    compared++;
    if (stable_a !== 4'h0 || press_a !== 4'h0) begin
      mismatched++;
      $display("FAIL glitch_settle: stable=%h press=%h, required 0/0", stable_a, press_a);
    end
  endtask

  task automatic test_two_bits;
    raw_a = 4'h5;
    tick(6);
    compared++;
    if (stable_a !== 4'hA || press_a !== 4'hA || release_a !== 4'h0) begin
      mismatched++;
      $display("FAIL two_press: stable=%h press=%h release=%h, required A/A/0", stable_a, press_a, release_a);
    end
    tick(1);
    compared++;
    if (stable_a !== 4'hA || press_a !== 4'h0) begin
      mismatched++;
      $display("FAIL two_press_end: stable=%h press=%h, required A/0", stable_a, press_a);
    end
    tick(13);
    raw_a = 4'hF;
    tick(5);
    compared++;
    if (stable_a !== 4'hA || release_a !== 4'h0) begin
      mismatched++;
      $display("FAIL two_release_early: stable=%h release=%h, required A/0", stable_a, release_a);
    end
    tick(1);
    compared++;
    if (stable_a !== 4'h0 || release_a !== 4'hA || press_a !== 4'h0) begin
      mismatched++;
      $display("FAIL two_release: stable=%h release=%h press=%h, required 0/A/0", stable_a, release_a, press_a);
    end
    tick(1);
    compared++;
    if (release_a !== 4'h0) begin
      mismatched++;
      $display("FAIL two_release_end: release=%h, required 0", release_a);
    end
  endtask

  task automatic test_reset_mid;
    raw_a = 4'hB;
    tick(4);
    rst = 1'b1;
    tick(1);
    compared++;
    if (stable_a !== 4'h0 || press_a !== 4'h0 || release_a !== 4'h0 || word_a !== 32'h0) begin
      mismatched++;
      $display("FAIL mid_reset: stable=%h press=%h release=%h word=%h, required 0",
               stable_a, press_a, release_a, word_a);
    end
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick(1);
      compared++;
      if (n < 6) begin
        if (stable_a !== 4'h0 || press_a !== 4'h0) begin
          mismatched++;
          $display("FAIL post_reset edge%0d: stable=%h press=%h, required 0/0", n, stable_a, press_a);
        end
      end else begin
        if (stable_a !== 4'h4 || press_a !== 4'h4) begin
          mismatched++;
          $display("FAIL post_reset edge6: stable=%h press=%h, required 4/4", stable_a, press_a);
        end
      end
    end
    tick(1);
    compared++;
    if (press_a !== 4'h0) begin
      mismatched++;
      $display("FAIL post_reset edge7: press=%h, required 0", press_a);
    end
    raw_a = 4'hF;
    tick(8);
    compared++;
    if (stable_a !== 4'h0) begin
      mismatched++;
      $display("FAIL post_reset_release: stable=%h, required 0", stable_a);
    end
  endtask

  task automatic test_hold_all;
    int  press_cnt [4];
    bit  seen;
    int  bad_cycles;
    for (int i = 0; i < 4; i++) press_cnt[i] = 0;
    seen       = 1'b0;
    bad_cycles = 0;
    raw_a      = 4'h0;
    for (int c = 0; c < 1000; c++) begin
      tick(1);
      for (int i = 0; i < 4; i++) if (press_a[i]) press_cnt[i]++;
      if (seen && stable_a !== 4'hF) bad_cycles++;
      if (press_a !== 4'h0) seen = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (press_cnt[i] !== 1) begin
        mismatched++;
        $display("FAIL hold_press_count bit%0d: got %0d pulses, required 1", i, press_cnt[i]);
      end
    end
    compared++;
    if (bad_cycles !== 0 || stable_a !== 4'hF) begin
      mismatched++;
      $display("FAIL hold_stable: %0d cycles not F, final stable=%h, required 0 and F", bad_cycles, stable_a);
    end
    raw_a = 4'hF;
    tick(8);
    compared++;
    if (stable_a !== 4'h0) begin
      mismatched++;
      $display("FAIL hold_release: stable=%h, required 0", stable_a);
    end
  endtask

  task automatic test_active_high;
    raw_b = 4'h4;
    tick(5);
    compared++;
    if (stable_b !== 4'h0 || press_b !== 4'h0) begin
      mismatched++;
      $display("FAIL ah_early: stable=%h press=%h, required 0/0", stable_b, press_b);
    end
    tick(1);
    compared++;
    if (stable_b !== 4'h4 || press_b !== 4'h4 || release_b !== 4'h0 || word_b !== 32'h4) begin
      mismatched++;
      $display("FAIL ah_press: stable=%h press=%h release=%h word=%h, required 4/4/0/00000004",
               stable_b, press_b, release_b, word_b);
    end
  endtask

  initial begin
    rst   = 1'b1;
    raw_a = 4'hF;
    raw_b = 4'h0;
    test_reset;
    test_single_press;
    test_glitch;
    test_two_bits;
    test_reset_mid;
    test_hold_all;
    test_active_high;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
